// File: rtl/score_digit_writer.sv
// Converts a 27-bit binary score to eight BCD digits by iterative double-dabble
// and writes them, least significant first, into an external 8-entry digit buffer.
module score_digit_writer #(
    parameter bit         BLANK_LEADING = 1'b1,
    parameter logic [3:0] BLANK_CODE    = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [26:0] score,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        digit_wr_en,
    output logic [2:0]  digit_wr_addr,
    output logic [3:0]  digit_wr_data
);

    // state   | meaning
    // IDLE    | waiting for load; captures score on acceptance
    // CONVERT | 27 double-dabble iterations, one binary bit per cycle
    // WRITE   | one digit write per cycle, address 0 through 7
    // DONE    | single-cycle completion pulse
    typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

    localparam logic [26:0] MAX_SCORE = 27'd99_999_999;

    state_t      state, next_state;
    logic [4:0]  cnt;
    logic [26:0] bin;
    logic [31:0] bcd;
    logic [31:0] bcd_adj;
    logic [31:0] bcd_sel;
    logic        blank;

    function automatic logic [31:0] add3(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 8; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd);

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = CONVERT;
            CONVERT: if (cnt == 5'd26) next_state = WRITE;
            WRITE:   if (cnt == 5'd7) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // cnt is the shift counter in CONVERT and the write address in WRITE
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= 5'd0;
            bin      <= 27'd0;
            bcd      <= 32'd0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin      <= (score > MAX_SCORE) ? MAX_SCORE : score;
                        overflow <= (score > MAX_SCORE);
                        bcd      <= 32'd0;
                        cnt      <= 5'd0;
                    end
                end
                CONVERT: begin
                    bcd <= {bcd_adj[30:0], bin[26]};
                    bin <= {bin[25:0], 1'b0};
                    cnt <= (cnt == 5'd26) ? 5'd0 : cnt + 5'd1;
                end
                WRITE: begin
                    cnt <= (cnt == 5'd7) ? 5'd0 : cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Digit at the current address and everything above it; all-zero means a leading zero
    assign bcd_sel = bcd >> {cnt[2:0], 2'b00};
    assign blank   = BLANK_LEADING && (cnt[2:0] != 3'd0) && (bcd_sel == 32'd0);

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        digit_wr_en   = 1'b0;
        digit_wr_addr = 3'd0;
        digit_wr_data = 4'd0;
        case (state)
            CONVERT: busy = 1'b1;
            WRITE: begin
                busy          = 1'b1;
                digit_wr_en   = 1'b1;
                digit_wr_addr = cnt[2:0];
                digit_wr_data = blank ? BLANK_CODE : bcd_sel[3:0];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
